// File: rtl/sent_pkg.sv
// Shared SENT receive definitions: decoder states, protocol constants and the CRC-4 step.
package sent_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_STATUS,
        ST_DATA,
        ST_CRC,
        ST_PAUSE
    } sent_state_e;

    localparam int unsigned SENT_SYNC_TICKS = 56;
    localparam int unsigned SENT_NIB_MIN    = 12;
    localparam int unsigned SENT_NIB_MAX    = 27;
    localparam logic [3:0]  SENT_CRC_SEED   = 4'h5;
    localparam int unsigned SENT_PAUSE_MAX  = 768;
    localparam logic [4:0]  SENT_CRC_POLY   = 5'h1D;

    // crc' = ((crc << 4) mod x^4+x^3+x^2+1) ^ nibble
    function automatic logic [3:0] sent_crc4_step(input logic [3:0] crc, input logic [3:0] nibble);
        logic [7:0] v;
        v = {crc, 4'b0000};
        for (int b = 7; b >= 4; b--) begin
            if (v[b]) begin
                v[b -: 5] = v[b -: 5] ^ SENT_CRC_POLY;
            end
        end
        return v[3:0] ^ nibble;
    endfunction

endpackage

// File: rtl/sent_rx_tick_meter.sv
// Synchronises the SENT line, detects falling edges and reports the rounded
// edge-to-edge interval in ticks with a one-cycle strobe.
module sent_rx_tick_meter #(
    parameter int unsigned TICK_CLKS = 30,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             clk_rx,
    input  logic             PRESETn_rx,
    input  logic             sent_rx_i,
    output logic             iv_valid_o,
    output logic [CNT_W-1:0] iv_ticks_o
);

    localparam int unsigned     PRE_W   = $clog2(TICK_CLKS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1_q, sync2_q, prev_q;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] ticks_q, ticks_d;
    logic             iv_valid_q, iv_valid_d;
    logic [CNT_W-1:0] iv_q, iv_d;
    logic             fe_c;
    logic             round_c;

    // Prescaler / saturating tick counter; both restart on every falling edge
    always_comb begin
        fe_c       = prev_q & ~sync2_q;
        round_c    = (presc_q >= PRE_W'(TICK_CLKS / 2));
        presc_d    = presc_q;
        ticks_d    = ticks_q;
        iv_valid_d = 1'b0;
        iv_d       = iv_q;
        if (fe_c) begin
            presc_d    = '0;
            ticks_d    = '0;
            iv_valid_d = 1'b1;
            iv_d       = (ticks_q == CNT_MAX) ? CNT_MAX : ticks_q + CNT_W'(round_c);
        end else if (presc_q == PRE_W'(TICK_CLKS - 1)) begin
            presc_d = '0;
            if (ticks_q != CNT_MAX) begin
                ticks_d = ticks_q + CNT_W'(1);
            end
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk_rx or negedge PRESETn_rx) begin
        if (!PRESETn_rx) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            presc_q    <= '0;
            ticks_q    <= '0;
            iv_valid_q <= 1'b0;
            iv_q       <= '0;
        end else begin
            sync1_q    <= sent_rx_i;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            presc_q    <= presc_d;
            ticks_q    <= ticks_d;
            iv_valid_q <= iv_valid_d;
            iv_q       <= iv_d;
        end
    end

    assign iv_valid_o = iv_valid_q;
    assign iv_ticks_o = iv_q;

endmodule

// File: rtl/sent_rx_frame_decoder.sv
// SENT receive frame decoder: sync recognition, status/data/CRC nibble decode, CRC-4 check.
// Optional post-CRC pause pulse acceptance is enabled by defining SENT_RX_PAUSE_EN.
module sent_rx_frame_decoder
    import sent_pkg::*;
#(
    parameter int unsigned TICK_CLKS    = 30,
    parameter int unsigned DATA_NIBBLES = 6,
    parameter int unsigned SYNC_TOL     = 2,
    parameter int unsigned CNT_W        = 10
) (
    input  logic                      clk_rx,
    input  logic                      PRESETn_rx,
    input  logic                      sent_rx_i,
    output logic                      frame_valid_o,
    output logic [3:0]                status_o,
    output logic [4*DATA_NIBBLES-1:0] data_o,
    output logic                      crc_err_o,
    output logic                      frame_err_o
);

    localparam int unsigned      DATA_W  = 4 * DATA_NIBBLES;
    localparam int unsigned      IDX_W   = (DATA_NIBBLES > 1) ? $clog2(DATA_NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(SENT_SYNC_TICKS - SYNC_TOL);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(SENT_SYNC_TICKS + SYNC_TOL);
    localparam logic [CNT_W-1:0] NIB_LO  = CNT_W'(SENT_NIB_MIN);
    localparam logic [CNT_W-1:0] NIB_HI  = CNT_W'(SENT_NIB_MAX);

    logic             iv_valid;
    logic [CNT_W-1:0] iv_ticks;

    sent_rx_tick_meter #(
        .TICK_CLKS (TICK_CLKS),
        .CNT_W     (CNT_W)
    ) u_tick_meter (
        .clk_rx     (clk_rx),
        .PRESETn_rx (PRESETn_rx),
        .sent_rx_i  (sent_rx_i),
        .iv_valid_o (iv_valid),
        .iv_ticks_o (iv_ticks)
    );

    sent_state_e       state_q, state_d;
    logic              from_crc_q, from_crc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        crc_q, crc_d;
    logic [3:0]        stat_sr_q, stat_sr_d;
    logic [DATA_W-1:0] data_sr_q, data_sr_d;
    logic              frame_valid_q, frame_valid_d;
    logic [3:0]        status_q, status_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              crc_err_q, crc_err_d;
    logic              frame_err_q, frame_err_d;

    logic              sat_c, is_sync_c, is_nib_c;
    logic [3:0]        nib_c;
`ifdef SENT_RX_PAUSE_EN
    logic              is_pause_c;
`endif

    // A saturated interval is never a legal sync or nibble
    always_comb begin
        sat_c     = (iv_ticks == CNT_MAX);
        is_sync_c = !sat_c && (iv_ticks >= SYNC_LO) && (iv_ticks <= SYNC_HI);
        is_nib_c  = !sat_c && (iv_ticks >= NIB_LO) && (iv_ticks <= NIB_HI);
        nib_c     = 4'(iv_ticks - NIB_LO);
`ifdef SENT_RX_PAUSE_EN
        is_pause_c = !sat_c && (iv_ticks >= NIB_LO) && (iv_ticks <= CNT_W'(SENT_PAUSE_MAX));
`endif
    end

    always_comb begin
        state_d       = state_q;
        from_crc_d    = from_crc_q;
        idx_d         = idx_q;
        crc_d         = crc_q;
        stat_sr_d     = stat_sr_q;
        data_sr_d     = data_sr_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        status_d      = status_q;
        data_d        = data_q;
        crc_err_d     = crc_err_q;

        if (iv_valid) begin
            // from_crc only qualifies the first interval judged in SYNC after a frame
            from_crc_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (is_sync_c) begin
                        state_d = ST_STATUS;
                        crc_d   = SENT_CRC_SEED;
                    end else begin
                        frame_err_d = from_crc_q;
                    end
                end
                ST_STATUS, ST_DATA, ST_CRC: begin
                    if (!is_nib_c) begin
                        frame_err_d = 1'b1;
                        state_d     = is_sync_c ? ST_STATUS : ST_SYNC;
                        crc_d       = SENT_CRC_SEED;
                    end else if (state_q == ST_STATUS) begin
                        stat_sr_d = nib_c;
                        idx_d     = '0;
                        state_d   = ST_DATA;
                    end else if (state_q == ST_DATA) begin
                        data_sr_d = DATA_W'({data_sr_q, nib_c});
                        crc_d     = sent_crc4_step(crc_q, nib_c);
                        if (idx_q == IDX_W'(DATA_NIBBLES - 1)) begin
                            state_d = ST_CRC;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        // Final zero nibble augments the CRC before comparison
                        frame_valid_d = 1'b1;
                        status_d      = stat_sr_q;
                        data_d        = data_sr_q;
                        crc_err_d     = (nib_c != sent_crc4_step(crc_q, 4'h0));
                        from_crc_d    = 1'b1;
`ifdef SENT_RX_PAUSE_EN
                        state_d       = ST_PAUSE;
`else
                        state_d       = ST_SYNC;
`endif
                    end
                end
`ifdef SENT_RX_PAUSE_EN
                ST_PAUSE: begin
                    if (is_sync_c) begin
                        state_d = ST_STATUS;
                        crc_d   = SENT_CRC_SEED;
                    end else if (is_pause_c) begin
                        state_d = ST_SYNC;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_SYNC;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_rx or negedge PRESETn_rx) begin
        if (!PRESETn_rx) begin
            state_q       <= ST_IDLE;
            from_crc_q    <= 1'b0;
            idx_q         <= '0;
            crc_q         <= '0;
            stat_sr_q     <= '0;
            data_sr_q     <= '0;
            frame_valid_q <= 1'b0;
            status_q      <= '0;
            data_q        <= '0;
            crc_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            from_crc_q    <= from_crc_d;
            idx_q         <= idx_d;
            crc_q         <= crc_d;
            stat_sr_q     <= stat_sr_d;
            data_sr_q     <= data_sr_d;
            frame_valid_q <= frame_valid_d;
            status_q      <= status_d;
            data_q        <= data_d;
            crc_err_q     <= crc_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign frame_valid_o = frame_valid_q;
    assign status_o      = status_q;
    assign data_o        = data_q;
    assign crc_err_o     = crc_err_q;
    assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_sent_rx_frame_decoder.sv
// Scoreboard bench for sent_rx_frame_decoder: drives SENT pulse trains and checks
// decoded frames and error strobes in line order; honours SENT_RX_PAUSE_EN.
module tb_sent_rx_frame_decoder;

    localparam int TC       = 10;
    localparam int NN       = 6;
    localparam int DW       = 4 * NN;
    localparam int LOW_CLKS = 5 * TC;
    localparam int SYNC_T   = 56;

    typedef struct packed {
        logic          is_err;
        logic [3:0]    st;
        logic [DW-1:0] data;
        logic          crc_err;
    } ev_t;

    logic          clk_rx = 1'b0;
    logic          PRESETn_rx;
    logic          sent_rx_i;
    logic          frame_valid_o;
    logic [3:0]    status_o;
    logic [DW-1:0] data_o;
    logic          crc_err_o;
    logic          frame_err_o;

    ev_t        exp_q[$];
    int         n_vec;
    int         n_miss;
    int         clk_cnt = 0;
    int         fe_cnt;
    logic [3:0] crc_tab [16];

    sent_rx_frame_decoder #(
        .TICK_CLKS    (TC),
        .DATA_NIBBLES (NN),
        .SYNC_TOL     (2),
        .CNT_W        (10)
    ) dut (
        .clk_rx        (clk_rx),
        .PRESETn_rx    (PRESETn_rx),
        .sent_rx_i     (sent_rx_i),
        .frame_valid_o (frame_valid_o),
        .status_o      (status_o),
        .data_o        (data_o),
        .crc_err_o     (crc_err_o),
        .frame_err_o   (frame_err_o)
    );

    always #5 clk_rx = ~clk_rx;
    always @(posedge clk_rx) clk_cnt <= clk_cnt + 1;

    function automatic logic [3:0] crc_model(input logic [DW-1:0] d);
        logic [3:0]    c;
        logic [DW-1:0] s;
        c = 4'h5;
        s = d;
        for (int i = 0; i < NN; i++) begin
            c = crc_tab[c] ^ s[DW-1 -: 4];
            s = s << 4;
        end
        return crc_tab[c];
    endfunction

    function automatic int nib_clks(input logic [3:0] v, input int adj);
        return (12 + int'(v)) * TC + adj;
    endfunction

    // Falling edge now (called at a negedge), line low for LOW_CLKS, then high
    task automatic drop();
        sent_rx_i = 1'b0;
        fe_cnt    = clk_cnt;
        repeat (LOW_CLKS) @(negedge clk_rx);
        sent_rx_i = 1'b1;
    endtask

    // Ends the running interval with a falling edge clks cycles after the previous one
    task automatic interval(input int clks);
        while (clk_cnt - fe_cnt < clks) @(negedge clk_rx);
        drop();
    endtask

    task automatic send_frame(input logic [3:0] st, input logic [DW-1:0] d,
                              input logic [3:0] crc, input bit stretch);
        ev_t           e;
        logic [DW-1:0] sh;
        int            adj;
        interval(stretch ? (SYNC_T * TC * 104) / 100 : SYNC_T * TC);
        interval(nib_clks(st, stretch ? 3 : 0));
        for (int i = 0; i < NN; i++) begin
            adj = stretch ? (((i % 2) == 0) ? -3 : 3) : 0;
            sh  = d >> (4 * (NN - 1 - i));
            interval(nib_clks(sh[3:0], adj));
        end
        e.is_err  = 1'b0;
        e.st      = st;
        e.data    = d;
        e.crc_err = (crc != crc_model(d));
        exp_q.push_back(e);
        interval(nib_clks(crc, stretch ? 3 : 0));
    endtask

    task automatic push_err();
        ev_t e;
        e = '0;
        e.is_err = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic check_drained(input string name);
        repeat (12) @(negedge clk_rx);
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_miss++;
            $display("FAIL %s pending_events got=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        PRESETn_rx = 1'b0;
        sent_rx_i  = 1'b1;
        repeat (4) @(negedge clk_rx);
        n_vec++; if (frame_valid_o !== 1'b0) begin n_miss++; $display("FAIL reset_valid got=%b want=0", frame_valid_o); end
        n_vec++; if (status_o !== 4'h0) begin n_miss++; $display("FAIL reset_status got=%h want=0", status_o); end
        n_vec++; if (data_o !== '0) begin n_miss++; $display("FAIL reset_data got=%h want=0", data_o); end
        n_vec++; if (crc_err_o !== 1'b0) begin n_miss++; $display("FAIL reset_crc_err got=%b want=0", crc_err_o); end
        n_vec++; if (frame_err_o !== 1'b0) begin n_miss++; $display("FAIL reset_frame_err got=%b want=0", frame_err_o); end
        PRESETn_rx = 1'b1;
        repeat (5) @(negedge clk_rx);
        drop();
    endtask

    task automatic test_zero_frame();
        send_frame(4'h3, 24'h000000, 4'h5, 1'b0);
        check_drained("zero_frame");
        n_vec++; if (status_o !== 4'h3) begin n_miss++; $display("FAIL zero_status got=%h want=3", status_o); end
    endtask

    task automatic test_crc_error();
        send_frame(4'h3, 24'h000000, 4'h6, 1'b0);
        check_drained("crc_error");
        n_vec++; if (crc_err_o !== 1'b1) begin n_miss++; $display("FAIL crc_err_hold got=%b want=1", crc_err_o); end
    endtask

    task automatic test_rounding();
        send_frame(4'hC, 24'hF12345, crc_model(24'hF12345), 1'b1);
        check_drained("rounding");
        n_vec++; if (data_o !== 24'hF12345) begin n_miss++; $display("FAIL rounding_data got=%h want=f12345", data_o); end
    endtask

    task automatic test_bad_nibble();
        interval(SYNC_T * TC);
        interval(nib_clks(4'h7, 0));
        interval(nib_clks(4'h4, 0));
        interval(nib_clks(4'h9, 0));
        push_err();
        interval(30 * TC);
        check_drained("bad_nibble");
        n_vec++; if (data_o !== 24'hF12345) begin n_miss++; $display("FAIL bad_nibble_data got=%h want=f12345", data_o); end
        n_vec++; if (status_o !== 4'hC) begin n_miss++; $display("FAIL bad_nibble_status got=%h want=c", status_o); end
        send_frame(4'hA, 24'h987654, crc_model(24'h987654), 1'b0);
        check_drained("after_bad_nibble");
    endtask

    task automatic test_pause();
        send_frame(4'h1, 24'h0A0B0C, crc_model(24'h0A0B0C), 1'b0);
`ifndef SENT_RX_PAUSE_EN
        push_err();
`endif
        interval(20 * TC);
        send_frame(4'h2, 24'h123456, crc_model(24'h123456), 1'b0);
        check_drained("pause");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic [3:0]    st;
        logic [3:0]    crc;
        for (int k = 0; k < 3; k++) begin
            d   = DW'($urandom);
            st  = 4'($urandom);
            crc = crc_model(d);
            if (k == 1) crc = crc ^ 4'h3;
            send_frame(st, d, crc, 1'b0);
        end
        check_drained("back_to_back");
    endtask

    task automatic test_reset_mid_frame();
        interval(SYNC_T * TC);
        interval(nib_clks(4'h5, 0));
        interval(nib_clks(4'h1, 0));
        interval(nib_clks(4'h2, 0));
        interval(nib_clks(4'h3, 0));
        repeat (20) @(negedge clk_rx);
        PRESETn_rx = 1'b0;
        sent_rx_i  = 1'b1;
        repeat (3) @(negedge clk_rx);
        n_vec++; if (data_o !== '0) begin n_miss++; $display("FAIL midrst_data got=%h want=0", data_o); end
        n_vec++; if (status_o !== 4'h0) begin n_miss++; $display("FAIL midrst_status got=%h want=0", status_o); end
        n_vec++; if (crc_err_o !== 1'b0) begin n_miss++; $display("FAIL midrst_crc_err got=%b want=0", crc_err_o); end
        n_vec++; if (exp_q.size() !== 0) begin n_miss++; $display("FAIL midrst_pending got=%0d want=0", exp_q.size()); end
        PRESETn_rx = 1'b1;
        repeat (20) @(negedge clk_rx);
        drop();
        for (int k = 0; k < 3; k++) interval(15 * TC);
        send_frame(4'h9, 24'h5A5A5A, crc_model(24'h5A5A5A), 1'b0);
        check_drained("reset_mid_frame");
    endtask

    initial begin
        sent_rx_i  = 1'b1;
        PRESETn_rx = 1'b0;
        n_vec      = 0;
        n_miss     = 0;
        fe_cnt     = 0;
        crc_tab    = '{4'd0, 4'd13, 4'd7, 4'd10, 4'd14, 4'd3, 4'd9, 4'd4,
                       4'd1, 4'd12, 4'd6, 4'd11, 4'd15, 4'd2, 4'd8, 4'd5};
        // Scoreboard: every strobe pops the oldest expected event
        fork
            forever begin
                ev_t e;
                @(negedge clk_rx);
                if (frame_valid_o === 1'b1 || frame_err_o === 1'b1) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_miss++;
                        $display("FAIL unexpected_event got valid=%b err=%b want=none", frame_valid_o, frame_err_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_err) begin
                            if ({frame_err_o, frame_valid_o} !== 2'b10) begin
                                n_miss++;
                                $display("FAIL frame_err_event got err=%b valid=%b want err=1 valid=0",
                                         frame_err_o, frame_valid_o);
                            end
                        end else if ({frame_err_o, frame_valid_o, status_o, data_o, crc_err_o} !==
                                     {2'b01, e.st, e.data, e.crc_err}) begin
                            n_miss++;
                            $display("FAIL frame_event got err=%b valid=%b st=%h data=%h crc_err=%b want err=0 valid=1 st=%h data=%h crc_err=%b",
                                     frame_err_o, frame_valid_o, status_o, data_o, crc_err_o,
                                     e.st, e.data, e.crc_err);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_zero_frame();
        test_crc_error();
        test_rounding();
        test_bad_nibble();
        test_pause();
        test_back_to_back();
        test_reset_mid_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
